serial_shifter: RTL and testbench

SERIAL_SHIFTER -- requirements
Module: serial_shifter

---
 rtl/serial_shifter_pkg.sv | 17 +
 rtl/serial_shifter_if.sv | 24 ++
 rtl/serial_shifter_shift_step.sv | 26 ++
 rtl/serial_shifter.sv | 92 +++++++++
 tb/tb_serial_shifter.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/serial_shifter_pkg.sv
// Shared constants, FSM state type and step helper for the serial shifter.
package shifter_pkg;

  localparam int WIDTH = 32;
  localparam int SHW   = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  function automatic logic [SHW-1:0] step_size(input logic four);
    return four ? SHW'(4) : SHW'(1);
  endfunction

endpackage

// File: rtl/serial_shifter_if.sv
// Request/result bus of the serial shifter; the master issues shifts, the shifter is the slave.
interface serial_shifter_if;
  import shifter_pkg::*;

  logic             start;
  logic [WIDTH-1:0] in;
  logic [SHW-1:0]   how_many;
  logic             dir;
  logic             arithmetic;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;

  modport master (
    output start, in, how_many, dir, arithmetic,
    input  busy, done, out
  );

  modport slave (
    input  start, in, how_many, dir, arithmetic,
    output busy, done, out
  );

endinterface

// File: rtl/serial_shifter_shift_step.sv
// One combinational shift step of 1 or 4 bits; the vacated bits are zero or the latched sign.
module shift_step
  import shifter_pkg::*;
(
  input  logic [WIDTH-1:0] data,
  input  logic             dir,
  input  logic             arithmetic,
  input  logic             sign,
  input  logic             four,
  output logic [WIDTH-1:0] result
);

  logic fill;

  // Sign fill applies only to arithmetic right shifts; every other case shifts in zeros.
  always_comb begin
    fill   = dir & arithmetic & sign;
    result = data;
    if (!dir) begin
      result = four ? {data[WIDTH-5:0], 4'b0000} : {data[WIDTH-2:0], 1'b0};
    end else begin
      result = four ? {{4{fill}}, data[WIDTH-1:4]} : {fill, data[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/serial_shifter.sv
// Multi-cycle serial shifter implementing RV32I SLL/SRL/SRA one small step per clock.
// Define SERIAL_SHIFTER_FAST_EN to step 4 bits per cycle while at least 4 remain.
module serial_shifter #(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  serial_shifter_if.slave bus
);
  import shifter_pkg::*;

  localparam int SHW = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d, step_out;
  logic [SHW-1:0]   count_q, count_d, step;
  logic             dir_q, dir_d;
  logic             arith_q, arith_d;
  logic             sign_q, sign_d;
  logic             use_four;

`ifdef SERIAL_SHIFTER_FAST_EN
  assign use_four = (count_q >= SHW'(4));
`else
  assign use_four = 1'b0;
`endif

  assign step = step_size(use_four);

  shift_step u_step (
    .data       (data_q),
    .dir        (dir_q),
    .arithmetic (arith_q),
    .sign       (sign_q),
    .four       (use_four),
    .result     (step_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      count_q <= '0;
      dir_q   <= 1'b0;
      arith_q <= 1'b0;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      count_q <= count_d;
      dir_q   <= dir_d;
      arith_q <= arith_d;
      sign_q  <= sign_d;
    end
  end

  // DONE accepts a new start exactly like IDLE, which gives back-to-back operation.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    count_d = count_q;
    dir_d   = dir_q;
    arith_d = arith_q;
    sign_d  = sign_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.start) begin
          data_d  = bus.in;
          count_d = bus.how_many;
          dir_d   = bus.dir;
          arith_d = bus.arithmetic;
          sign_d  = bus.in[WIDTH-1];
          state_d = (bus.how_many != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        data_d  = step_out;
        count_d = count_q - step;
        if (count_d == '0) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy = (state_q == SHIFT);
  assign bus.done = (state_q == DONE);
  assign bus.out  = data_q;

endmodule

// File: tb/tb_serial_shifter.sv
// Directed, table-driven self-checking bench for serial_shifter (step-1 or fast build).
module tb_serial_shifter;

  typedef struct {
    logic [31:0] in;
    logic [4:0]  how_many;
    logic        dir;
    logic        arith;
    logic [31:0] exp_out;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   failed = 0;
  vec_t vecs[$];

  serial_shifter_if bus();

  serial_shifter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic int expEdges(input int n);
`ifdef SERIAL_SHIFTER_FAST_EN
    return n / 4 + n % 4 + 1;
`else
    return n + 1;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Starts one operation and counts edges (including the sampling edge) until done.
  task automatic applyStimulus(input vec_t v, output int edges, output logic busy_any);
    logic seen;
    @(negedge clk);
    bus.start      = 1'b1;
    bus.in         = v.in;
    bus.how_many   = v.how_many;
    bus.dir        = v.dir;
    bus.arithmetic = v.arith;
    edges    = 0;
    busy_any = 1'b0;
    seen     = 1'b0;
    while (!seen && edges < 80) begin
      @(posedge clk);
      #1;
      edges++;
      bus.start = 1'b0;
      if (bus.busy) busy_any = 1'b1;
      if (bus.done) seen = 1'b1;
    end
  endtask

  initial begin
    int   edges;
    logic busy_any;
    logic done_any;
    logic seen;
    vec_t v;

    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.in         = '0;
    bus.how_many   = '0;
    bus.dir        = 1'b0;
    bus.arithmetic = 1'b0;

    for (int n = 0; n < 32; n++) begin
      vecs.push_back('{32'hFFFF_FFFF, 5'(n), 1'b0, 1'b0, 32'hFFFF_FFFF << n});
    end
    vecs.push_back('{32'h8000_0000, 5'd31, 1'b1, 1'b1, 32'hFFFF_FFFF});
    vecs.push_back('{32'h8000_0000, 5'd31, 1'b1, 1'b0, 32'h0000_0001});
    vecs.push_back('{32'h1234_5678, 5'd0,  1'b1, 1'b1, 32'h1234_5678});
    vecs.push_back('{32'h0000_0001, 5'd31, 1'b0, 1'b0, 32'h8000_0000});
    vecs.push_back('{32'h8765_4321, 5'd4,  1'b1, 1'b1, 32'hF876_5432});
    vecs.push_back('{32'h8765_4321, 5'd8,  1'b1, 1'b0, 32'h0087_6543});
    vecs.push_back('{32'h0000_ABCD, 5'd12, 1'b0, 1'b0, 32'h0ABC_D000});
    vecs.push_back('{32'h8000_0001, 5'd1,  1'b0, 1'b1, 32'h0000_0002});
    vecs.push_back('{32'h7000_0000, 5'd28, 1'b1, 1'b1, 32'h0000_0007});
    vecs.push_back('{32'hF0F0_0000, 5'd5,  1'b1, 1'b1, 32'hFF87_8000});
    vecs.push_back('{32'h1234_5678, 5'd0,  1'b0, 1'b0, 32'h1234_5678});

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_out", bus.out, 32'h0);
    checkOutput("reset_busy", 32'(bus.busy), 32'h0);
    checkOutput("reset_done", 32'(bus.done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Consecutive vectors start while the previous one is in DONE, exercising back-to-back.
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i], edges, busy_any);
      checkOutput($sformatf("vec%0d_out", i), bus.out, vecs[i].exp_out);
      checkOutput($sformatf("vec%0d_edges", i), 32'(edges), 32'(expEdges(int'(vecs[i].how_many))));
      checkOutput($sformatf("vec%0d_busy", i), 32'(busy_any), 32'(vecs[i].how_many != 5'd0));
    end

    @(posedge clk);
    #1;
    checkOutput("done_one_cycle", 32'(bus.done), 32'h0);
    checkOutput("out_held_idle", bus.out, 32'h1234_5678);

    // Start pulsed mid-SHIFT with different operands must be ignored.
    @(negedge clk);
    bus.start = 1'b1; bus.in = 32'h0000_00F0; bus.how_many = 5'd8; bus.dir = 1'b0; bus.arithmetic = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    edges = 1;
    @(negedge clk);
    bus.start = 1'b1; bus.in = 32'hFFFF_FFFF; bus.how_many = 5'd2; bus.dir = 1'b1; bus.arithmetic = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    edges = 2;
    seen = bus.done;
    while (!seen && edges < 80) begin
      @(posedge clk);
      #1;
      edges++;
      seen = bus.done;
    end
    checkOutput("midstart_out", bus.out, 32'h0000_F000);
    checkOutput("midstart_edges", 32'(edges), 32'(expEdges(8)));
    @(posedge clk);
    #1;
    checkOutput("midstart_done_drop", 32'(bus.done), 32'h0);
    checkOutput("midstart_out_held", bus.out, 32'h0000_F000);

    // Reset during a long shift aborts it without a done pulse.
    @(negedge clk);
    bus.start = 1'b1; bus.in = 32'hDEAD_BEEF; bus.how_many = 5'd20; bus.dir = 1'b0; bus.arithmetic = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("abort_busy_before", 32'(bus.busy), 32'h1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_out", bus.out, 32'h0);
    checkOutput("abort_busy", 32'(bus.busy), 32'h0);
    checkOutput("abort_done", 32'(bus.done), 32'h0);
    done_any = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (bus.done) done_any = 1'b1;
    end
    checkOutput("abort_no_done", 32'(done_any), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    v = '{32'h8000_0010, 5'd3, 1'b1, 1'b1, 32'hF000_0002};
    applyStimulus(v, edges, busy_any);
    checkOutput("post_reset_out", bus.out, 32'hF000_0002);
    checkOutput("post_reset_edges", 32'(edges), 32'(expEdges(3)));

    @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
